trace_cmd_queue: RTL and testbench

- Clocked buffering and validation stage between the trace-file reader and cache_statistics.
- Accepts parsed trace commands with their addresses over a valid/ready handshake and filters out illegal command codes.
- Buffers legal entries in a FIFO and replays them to the statistics stage in order, one per handshake.
- Turns the reader's end-of-file into a clean end-of-stream flag that rises only after the queue has fully drained.

---
 rtl/trace_cmd_queue.sv | 112 +++++++++++
 tb/tb_trace_cmd_queue.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_cmd_queue.sv
// Validating FIFO between the trace-file reader and cache_statistics.
// Drops illegal command codes, buffers legal ones, and raises out_eof once the stream has drained.
module trace_cmd_queue #(
   parameter int CMD_W  = 4,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [CMD_W-1:0]             in_command,
   input  logic [ADDR_W-1:0]            in_address,
   input  logic                         in_eof,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [CMD_W-1:0]             out_command,
   output logic [ADDR_W-1:0]            out_address,
   output logic                         out_eof,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [CNT_W-1:0]             accepted_cnt,
   output logic [CNT_W-1:0]             dropped_cnt,
   output logic                         late_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {ACTIVE, DRAIN, DONE} state_t;

   state_t            state;
   logic [CMD_W-1:0]  mem_cmd  [DEPTH];
   logic [ADDR_W-1:0] mem_addr [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic              legal;
   logic              in_hs;
   logic              push;
   logic              pop;
   logic [CW-1:0]     count_next;

   always_comb begin
      legal = 1'b0;
      if (in_command <= CMD_W'(6))
         legal = 1'b1;
      if (in_command == CMD_W'(8) || in_command == CMD_W'(9))
         legal = 1'b1;
   end

   assign in_ready  = (state == ACTIVE) && (count != FULL);
   assign out_valid = (count != '0);
   assign in_hs     = in_valid & in_ready;
   assign push      = in_hs & legal;
   assign pop       = out_valid & out_ready;
   assign out_eof   = (state == DONE);

   // Head is gated so the outputs read zero whenever the queue is empty.
   assign out_command = out_valid ? mem_cmd[rd_ptr]  : '0;
   assign out_address = out_valid ? mem_addr[rd_ptr] : '0;

   always_comb begin
      count_next = count;
      if (push && !pop)
         count_next = count + CW'(1);
      else if (pop && !push)
         count_next = count - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_cmd[wr_ptr]  <= in_command;
         mem_addr[wr_ptr] <= in_address;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ACTIVE;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         accepted_cnt <= '0;
         dropped_cnt  <= '0;
         late_err     <= 1'b0;
      end else begin
         count <= count_next;
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);

         if (push && accepted_cnt != '1)
            accepted_cnt <= accepted_cnt + CNT_W'(1);
         if (in_hs && !legal && dropped_cnt != '1)
            dropped_cnt <= dropped_cnt + CNT_W'(1);

         if (state != ACTIVE && in_valid)
            late_err <= 1'b1;

         // A push accepted alongside in_eof is the final entry and is counted in count_next.
         case (state)
            ACTIVE: if (in_eof) state <= (count_next == '0) ? DONE : DRAIN;
            DRAIN:  if (count_next == '0) state <= DONE;
            DONE:   state <= DONE;
            default: state <= ACTIVE;
         endcase
      end
   end

endmodule

// File: tb/tb_trace_cmd_queue.sv
// Scoreboard bench for trace_cmd_queue: legal handshakes are queued as expected output,
// popped and compared when the DUT delivers them.
module tb_trace_cmd_queue;

   localparam int CMD_W  = 4;
   localparam int ADDR_W = 32;
   localparam int DEPTH  = 8;
   localparam int CNT_W  = 4;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 in_valid = 1'b0;
   logic                 in_eof = 1'b0;
   logic                 out_ready = 1'b0;
   logic [CMD_W-1:0]     in_command = '0;
   logic [ADDR_W-1:0]    in_address = '0;
   logic                 in_ready;
   logic                 out_valid;
   logic                 out_eof;
   logic                 late_err;
   logic [CMD_W-1:0]     out_command;
   logic [ADDR_W-1:0]    out_address;
   logic [3:0]           count;
   logic [CNT_W-1:0]     accepted_cnt;
   logic [CNT_W-1:0]     dropped_cnt;

   int total = 0;
   int bad   = 0;
   int pops  = 0;
   logic [CMD_W+ADDR_W-1:0] exp_q[$];
   logic [CMD_W+ADDR_W-1:0] prev_head;
   logic [CMD_W+ADDR_W-1:0] e;
   logic                    have_prev = 1'b0;

   trace_cmd_queue #(
      .CMD_W  (CMD_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_command   (in_command),
      .in_address   (in_address),
      .in_eof       (in_eof),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_command  (out_command),
      .out_address  (out_address),
      .out_eof      (out_eof),
      .count        (count),
      .accepted_cnt (accepted_cnt),
      .dropped_cnt  (dropped_cnt),
      .late_err     (late_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic bit is_legal(input logic [CMD_W-1:0] c);
      return c inside {[4'd0:4'd6], 4'd8, 4'd9};
   endfunction

   // Inputs are stable at the falling edge, so handshakes seen here happen on the next rising edge.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         have_prev = 1'b0;
      end else begin
         if (have_prev) begin
            total++;
            if ({out_command, out_address} !== prev_head) begin
               bad++;
               $display("FAIL hold_stable: got %h want %h", {out_command, out_address}, prev_head);
            end
         end
         if (out_valid && out_ready) begin
            total++;
            pops++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_pop: got %h want none", {out_command, out_address});
            end else begin
               e = exp_q.pop_front();
               if ({out_command, out_address} !== e) begin
                  bad++;
                  $display("FAIL pop_order: got %h want %h", {out_command, out_address}, e);
               end
            end
         end
         have_prev = out_valid && !out_ready;
         prev_head = {out_command, out_address};
         if (in_valid && in_ready && is_legal(in_command))
            exp_q.push_back({in_command, in_address});
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      in_eof = 1'b0;
      out_ready = 1'b0;
      rst = 1'b1;
      step(2);
      pops = 0;
      rst = 1'b0;
   endtask

   task automatic push(input logic [CMD_W-1:0] c, input logic [ADDR_W-1:0] a);
      int unsigned n = 0;
      in_valid = 1'b1;
      in_command = c;
      in_address = a;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL push_ready: got %b want 1 (cmd %0d)", in_ready, c);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && count != 0; i++)
         step(1);
      total++;
      if (count !== 4'd0 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: count %0d queue %0d want 0 0", count, exp_q.size());
      end
   endtask

   task automatic test_reset();
      do_reset();
      step(2);
      total++;
      if ({in_ready, out_valid, out_eof, late_err} !== 4'b1000) begin
         bad++;
         $display("FAIL reset_flags: got %b want 1000", {in_ready, out_valid, out_eof, late_err});
      end
      total++;
      if (count !== 4'd0 || accepted_cnt !== 4'd0 || dropped_cnt !== 4'd0) begin
         bad++;
         $display("FAIL reset_counts: got %0d %0d %0d want 0 0 0", count, accepted_cnt, dropped_cnt);
      end
      total++;
      if (out_command !== 4'd0 || out_address !== 32'd0) begin
         bad++;
         $display("FAIL reset_head: got %h %h want 0 0", out_command, out_address);
      end
   endtask

   task automatic test_midreset();
      do_reset();
      for (int i = 0; i < 3; i++)
         push(4'(i + 1), 32'h5000_0000 + 32'(i));
      do_reset();
      out_ready = 1'b1;
      step(3);
      total++;
      if (count !== 4'd0 || out_valid !== 1'b0 || pops != 0) begin
         bad++;
         $display("FAIL midreset: count %0d valid %b pops %0d want 0 0 0", count, out_valid, pops);
      end
   endtask

   task automatic test_single_pass();
      do_reset();
      out_ready = 1'b1;
      push(4'd0, 32'h1000_0040);
      total++;
      if (out_valid !== 1'b1 || out_command !== 4'd0 || out_address !== 32'h1000_0040 || count !== 4'd1) begin
         bad++;
         $display("FAIL single_latency: got v%b %h %h c%0d want v1 0 10000040 c1",
                  out_valid, out_command, out_address, count);
      end
      step(1);
      total++;
      if (count !== 4'd0 || out_valid !== 1'b0 || accepted_cnt !== 4'd1 || pops != 1) begin
         bad++;
         $display("FAIL single_pop: count %0d valid %b acc %0d pops %0d want 0 0 1 1",
                  count, out_valid, accepted_cnt, pops);
      end
   endtask

   task automatic test_filter();
      do_reset();
      out_ready = 1'b1;
      push(4'd7,  32'h0000_0007);
      push(4'd12, 32'h0000_000C);
      push(4'd3,  32'hDEAD_BEEF);
      push(4'd9,  32'h0000_0009);
      drain();
      step(1);
      total++;
      if (accepted_cnt !== 4'd2 || dropped_cnt !== 4'd2 || pops != 2) begin
         bad++;
         $display("FAIL filter: acc %0d drop %0d pops %0d want 2 2 2", accepted_cnt, dropped_cnt, pops);
      end
   endtask

   task automatic test_full();
      int unsigned n = 0;
      do_reset();
      out_ready = 1'b1;
      push(4'd1, 32'h0000_0001);
      push(4'd2, 32'h0000_0002);
      push(4'd4, 32'h0000_0003);
      drain();
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++)
         push(4'(i % 7), 32'hA000_0000 + 32'(i * 4));
      total++;
      if (count !== 4'd8 || in_ready !== 1'b0 || accepted_cnt !== 4'd11) begin
         bad++;
         $display("FAIL full: count %0d ready %b acc %0d want 8 0 11", count, in_ready, accepted_cnt);
      end
      in_valid = 1'b1;
      in_command = 4'd9;
      in_address = 32'hA000_0100;
      step(3);
      total++;
      if (count !== 4'd8 || accepted_cnt !== 4'd11 || late_err !== 1'b0) begin
         bad++;
         $display("FAIL full_hold: count %0d acc %0d late %b want 8 11 0", count, accepted_cnt, late_err);
      end
      out_ready = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL full_release: ready %b want 1", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      drain();
      total++;
      if (accepted_cnt !== 4'd12 || pops != 12) begin
         bad++;
         $display("FAIL full_total: acc %0d pops %0d want 12 12", accepted_cnt, pops);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         push(4'(i), 32'hB000_0000 + 32'(i));
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         push(4'(8 + (i % 2)), 32'hC000_0000 + 32'(i));
         total++;
         if (count !== 4'd4) begin
            bad++;
            $display("FAIL simul_count: got %0d want 4 (cycle %0d)", count, i);
         end
      end
      drain();
      total++;
      if (pops != 14 || accepted_cnt !== 4'd14) begin
         bad++;
         $display("FAIL simul_total: pops %0d acc %0d want 14 14", pops, accepted_cnt);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         push(4'd5, 32'(i));
         push(4'd11, 32'(i));
      end
      drain();
      total++;
      if (accepted_cnt !== 4'd15 || dropped_cnt !== 4'd15) begin
         bad++;
         $display("FAIL saturate: acc %0d drop %0d want 15 15", accepted_cnt, dropped_cnt);
      end
   endtask

   task automatic test_eof();
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         push(4'(i + 4), 32'hE000_0000 + 32'(i));
      in_eof = 1'b1;
      push(4'd8, 32'hE000_00FF);
      in_eof = 1'b0;
      total++;
      if (in_ready !== 1'b0 || out_eof !== 1'b0 || count !== 4'd4 || late_err !== 1'b0) begin
         bad++;
         $display("FAIL eof_drain: ready %b eof %b count %0d late %b want 0 0 4 0",
                  in_ready, out_eof, count, late_err);
      end
      in_valid = 1'b1;
      in_command = 4'd2;
      step(1);
      in_valid = 1'b0;
      total++;
      if (late_err !== 1'b1 || accepted_cnt !== 4'd4 || dropped_cnt !== 4'd0 || count !== 4'd4) begin
         bad++;
         $display("FAIL late_err: late %b acc %0d drop %0d count %0d want 1 4 0 4",
                  late_err, accepted_cnt, dropped_cnt, count);
      end
      out_ready = 1'b1;
      step(3);
      total++;
      if (count !== 4'd1 || out_eof !== 1'b0) begin
         bad++;
         $display("FAIL eof_early: count %0d eof %b want 1 0", count, out_eof);
      end
      step(1);
      total++;
      if (count !== 4'd0 || out_eof !== 1'b1 || out_valid !== 1'b0 || pops != 4) begin
         bad++;
         $display("FAIL eof_rise: count %0d eof %b valid %b pops %0d want 0 1 0 4",
                  count, out_eof, out_valid, pops);
      end
      step(2);
      total++;
      if (out_eof !== 1'b1 || in_ready !== 1'b0) begin
         bad++;
         $display("FAIL eof_hold: eof %b ready %b want 1 0", out_eof, in_ready);
      end
      do_reset();
      step(1);
      total++;
      if ({in_ready, out_valid, out_eof, late_err} !== 4'b1000 || accepted_cnt !== 4'd0 || count !== 4'd0) begin
         bad++;
         $display("FAIL eof_reset: flags %b acc %0d count %0d want 1000 0 0",
                  {in_ready, out_valid, out_eof, late_err}, accepted_cnt, count);
      end
   endtask

   initial begin
      test_reset();
      test_midreset();
      test_single_pass();
      test_filter();
      test_full();
      test_back_to_back();
      test_saturate();
      test_eof();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
